seg7_bcd_display: RTL and testbench
===================================

// Module: seg7_bcd_display
// PURPOSE
//  Parametrised display front end: loads a binary value, converts it to BCD by
//  iterative shift-add-3 (double-dabble), drives N_DIGITS registered active-low
//  7-segment outputs. Replaces per-digit decoders fed with pre-split nibbles;
//  sits between the application FSM (price/change/balance) and the HEX pins.
// PARAMETERS
//  WIDTH      8   binary input width, 4..32
//  N_DIGITS   4   displayed digits, 1..8
//  BLINK_DIV  24  blink toggles when a BLINK_DIV-bit free counter wraps (BLINK_EN only)
// PORTS
//  clk_i         in   1            system clock
//  n_reset_i     in   1            async active-low reset
//  value_i       in   WIDTH        binary value, sampled on load_i
//  load_i        in   1            start conversion; ignored while busy_o=1
//  blank_lz_i    in   1            1 = blank leading zeros, sampled with value_i
//  blink_mask_i  in   N_DIGITS     per-digit blink enable (BLINK_EN only)
//  busy_o        out  1            conversion in progress
//  done_o        out  1            one-cycle pulse, new segments valid
//  ovf_o         out  1            last value exceeded 10^N_DIGITS-1
//  seg_o         out  7*N_DIGITS   digit k at [7k+6:7k], k=0 least significant; bit0=a..bit6=g, 0=lit
// BEHAVIOUR
//  Reset: FSM IDLE, busy_o=0, done_o=0, ovf_o=0, seg_o all 1 (blank), shift/BCD regs 0.
//  FSM: IDLE -load_i-> SHIFT (WIDTH cycles, counter WIDTH-1..0) -> UPDATE (1 cycle) -> IDLE.
//  Load edge n: value_i, blank_lz_i captured; busy_o=1 from n+1.
//  SHIFT: each cycle every BCD digit >=5 gets +3, then {bcd,shift} shifts left 1.
//  UPDATE: seg_o, ovf_o registered; done_o=1 for that cycle only; busy_o drops next cycle.
//  Latency load edge -> seg_o update edge = WIDTH+1 cycles; seg_o holds old value meanwhile.
//  Internal BCD width: BCD_DIGITS = (WIDTH*3)/10+1 digits (enough for 2^WIDTH-1).
//  Overflow: any BCD digit index >= N_DIGITS nonzero -> ovf_o=1, all digits show '-'
//   (only g lit, 7'b0111111), blanking ignored.
//  Leading-zero blank: digits above highest nonzero digit are 7'h7F; digit 0 never
//   blanked (value 0 shows single '0').
//  Glyphs 0-9 fixed table; BCD digit >9 impossible, decodes to blank if reached.
//  load_i during SHIFT/UPDATE dropped (no queuing); load_i in UPDATE cycle also dropped.
//  Reset mid-conversion: immediate return to reset state, no done_o.
// CONFIGURATION
//  SEG7_BLINK_EN defined: BLINK_DIV-bit counter free-runs from reset; phase bit toggles
//   on each wrap; while phase=1, digits with blink_mask_i[k]=1 forced blank (7'h7F),
//   combinationally masked after the seg register (mask change visible same cycle).
//   Overflow '-' also blinks.
//  Undefined: no counter, blink_mask_i present but ignored, seg_o = registered value.
// STRUCTURE
//  seg7_pkg: glyph constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, function
//   seg7_glyph(4-bit)->7-bit, FSM state encoding (IDLE/SHIFT/UPDATE).
//  Sub-module seg7_bcd_conv: FSM + double-dabble engine, outputs BCD vector + done.
//  Top: overflow detect, leading-zero blanking, seg register, optional blink.
// TESTING
//  WIDTH=8,N=4: reset -> seg_o=all 1, busy_o=0; load 8'd0 -> after 9 cycles
//   done_o pulse, digit0=7'h40 ('0'), digits 1-3 blank (blank_lz_i=1).
//  load 8'd255, blank_lz_i=0 -> done at +9, digits 3..0 = '0','2','5','5'
//   (7'h40,7'h24,7'h12,7'h12), ovf_o=0.
//  WIDTH=8,N=2: load 8'd100 -> ovf_o=1, both digits 7'h3F; then load 8'd99
//   -> ovf_o=0, '9','9' (7'h10,7'h10).
//  load 8'd42 then load_i pulses on cycles +3 and +9 -> exactly one done_o,
//   display '42'; busy_o high 9 cycles only.
//  Assert n_reset_i=0 at cycle +5 of conversion -> seg_o all 1, no done_o,
//   next load converts normally.
//  SEG7_BLINK_EN, BLINK_DIV=4, mask=4'b0001, value 7 -> digit0 alternates
//   7'h78/7'h7F every 16 cycles; other digits unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants, converter state encoding and decode helpers for seg7_bcd_display
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } conv_state_e;

    // Enough BCD digits to hold 2^w-1.
    function automatic int bcd_digits(input int w);
        return (w * 3) / 10 + 1;
    endfunction

    // Active-low segments, bit0=a .. bit6=g.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_bcd_display_if.sv
// rtl/seg7_bcd_display_if.sv - load/status/segment bundle between the application FSM and the display front end
interface seg7_bcd_display_if #(
    parameter int WIDTH    = 8,
    parameter int N_DIGITS = 4
);
    logic [WIDTH-1:0]      value_i;
    logic                  load_i;
    logic                  blank_lz_i;
    logic [N_DIGITS-1:0]   blink_mask_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  ovf_o;
    logic [7*N_DIGITS-1:0] seg_o;

    modport master (
        output value_i, load_i, blank_lz_i, blink_mask_i,
        input  busy_o, done_o, ovf_o, seg_o
    );

    modport slave (
        input  value_i, load_i, blank_lz_i, blink_mask_i,
        output busy_o, done_o, ovf_o, seg_o
    );
endinterface

// File: rtl/seg7_bcd_conv.sv
// rtl/seg7_bcd_conv.sv - iterative double-dabble binary-to-BCD engine with IDLE/SHIFT/UPDATE FSM
module seg7_bcd_conv
    import seg7_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = bcd_digits(WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    n_reset_i,
    input  logic [WIDTH-1:0]        value_i,
    input  logic                    load_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int CW = $clog2(WIDTH);

    conv_state_e             state;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        shift_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // done_o marks the UPDATE cycle; the top registers the display on it.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_i) begin
                        state   <= ST_SHIFT;
                        cnt     <= CW'(WIDTH - 1);
                        shift_q <= value_i;
                        bcd_q   <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state  <= ST_UPDATE;
                        done_o <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/seg7_bcd_display.sv
// rtl/seg7_bcd_display.sv - binary-to-7-segment display front end; SEG7_BLINK_EN adds per-digit blinking
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_DIGITS  = 4,
    parameter int BLINK_DIV = 24
) (
    input  logic               clk_i,
    input  logic               n_reset_i,
    seg7_bcd_display_if.slave  bus
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int MAXD       = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;

    logic                    conv_busy;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [4*MAXD-1:0]       bcd_pad;
    logic                    blank_q;
    logic                    ovf_next;
    logic [3:0]              hi_digit;
    logic [7*N_DIGITS-1:0]   seg_next;
    logic [7*N_DIGITS-1:0]   seg_q;
    logic                    ovf_q;
    logic                    done_q;

    seg7_bcd_conv #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk_i     (clk_i),
        .n_reset_i (n_reset_i),
        .value_i   (bus.value_i),
        .load_i    (bus.load_i),
        .busy_o    (conv_busy),
        .done_o    (conv_done),
        .bcd_o     (bcd)
    );

    // Padding lets overflow and display loops index any digit without range checks.
    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*BCD_DIGITS-1:0] = bcd;
        ovf_next = 1'b0;
        for (int i = N_DIGITS; i < MAXD; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0)
                ovf_next = 1'b1;
        end
        hi_digit = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (bcd_pad[4*k +: 4] != 4'd0)
                hi_digit = 4'(k);
        end
        seg_next = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (ovf_next)
                seg_next[7*k +: 7] = SEG_DASH;
            else if (blank_q && (4'(k) > hi_digit))
                seg_next[7*k +: 7] = SEG_BLANK;
            else
                seg_next[7*k +: 7] = seg7_glyph(bcd_pad[4*k +: 4]);
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            blank_q <= 1'b0;
            seg_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (bus.load_i && !conv_busy)
                blank_q <= bus.blank_lz_i;
            done_q <= conv_done;
            if (conv_done) begin
                seg_q <= seg_next;
                ovf_q <= ovf_next;
            end
        end
    end

    assign bus.busy_o = conv_busy;
    assign bus.done_o = done_q;
    assign bus.ovf_o  = ovf_q;

`ifdef SEG7_BLINK_EN
    logic [BLINK_DIV-1:0]  blink_cnt;
    logic                  blink_phase;
    logic [7*N_DIGITS-1:0] seg_blink;

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt)
                blink_phase <= ~blink_phase;
        end
    end

    // Mask applied after the register so a mask change shows immediately.
    always_comb begin
        seg_blink = seg_q;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (blink_phase && bus.blink_mask_i[k])
                seg_blink[7*k +: 7] = SEG_BLANK;
        end
    end

    assign bus.seg_o = seg_blink;
`else
    localparam int unused_blink_div = BLINK_DIV;
    wire unused_blink_mask = ^bus.blink_mask_i;

    assign bus.seg_o = seg_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb/tb_seg7_bcd_display.sv - directed self-checking bench for seg7_bcd_display (N=4 and N=2 instances)
module tb_seg7_bcd_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seg7_bcd_display_if #(.WIDTH(8), .N_DIGITS(4)) bus_a ();
    seg7_bcd_display_if #(.WIDTH(8), .N_DIGITS(2)) bus_b ();

    seg7_bcd_display #(.WIDTH(8), .N_DIGITS(4), .BLINK_DIV(4)) dut_a (
        .clk_i     (clk),
        .n_reset_i (rst_n),
        .bus       (bus_a.slave)
    );

    seg7_bcd_display #(.WIDTH(8), .N_DIGITS(2), .BLINK_DIV(4)) dut_b (
        .clk_i     (clk),
        .n_reset_i (rst_n),
        .bus       (bus_b.slave)
    );

    logic [27:0] prev_a = 28'hFFFFFFF;
    logic [27:0] prev_b = 28'h0003FFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] seg_of(input logic sel);
        return sel ? {14'd0, bus_b.seg_o} : bus_a.seg_o;
    endfunction

    task automatic set_load(input logic sel, input logic l, input logic [7:0] v, input logic blank);
        if (sel) begin
            bus_b.load_i = l; bus_b.value_i = v; bus_b.blank_lz_i = blank;
        end else begin
            bus_a.load_i = l; bus_a.value_i = v; bus_a.blank_lz_i = blank;
        end
    endtask

    task automatic conv(input string tag, input logic sel, input logic [7:0] val, input logic blank,
                        input bit extra, input logic [27:0] exp_seg, input logic exp_ovf);
        int done_at = -1;
        int done_n  = 0;
        int busy_n  = 0;
        logic d, b;
        @(negedge clk);
        set_load(sel, 1'b1, val, blank);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0 || c == 3 || c == 9) set_load(sel, 1'b0, val, blank);
            if (extra && (c == 2 || c == 8)) set_load(sel, 1'b1, 8'd77, blank);
            d = sel ? bus_b.done_o : bus_a.done_o;
            b = sel ? bus_b.busy_o : bus_a.busy_o;
            if (d) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (b) busy_n++;
            if (c == 4) chk({tag, "_hold"}, seg_of(sel), sel ? prev_b : prev_a);
        end
        chk({tag, "_done_at"}, done_at, 9);
        chk({tag, "_done_n"}, done_n, 1);
        chk({tag, "_busy_n"}, busy_n, 9);
        chk({tag, "_seg"}, seg_of(sel), exp_seg);
        chk({tag, "_ovf"}, sel ? bus_b.ovf_o : bus_a.ovf_o, exp_ovf);
        if (sel) prev_b = exp_seg; else prev_a = exp_seg;
    endtask

    initial begin
        int seen;
        bus_a.load_i = 0; bus_a.value_i = '0; bus_a.blank_lz_i = 0; bus_a.blink_mask_i = '0;
        bus_b.load_i = 0; bus_b.value_i = '0; bus_b.blank_lz_i = 0; bus_b.blink_mask_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_seg_a", bus_a.seg_o, 28'hFFFFFFF);
        chk("rst_seg_b", bus_b.seg_o, 14'h3FFF);
        chk("rst_busy_a", bus_a.busy_o, 0);
        chk("rst_done_a", bus_a.done_o, 0);
        chk("rst_ovf_a", bus_a.ovf_o, 0);
        rst_n = 1'b1;

        conv("zero_lz", 0, 8'd0, 1, 0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 0);
        conv("v255", 0, 8'd255, 0, 0, {7'h40, 7'h24, 7'h12, 7'h12}, 0);
        conv("v7_lz", 0, 8'd7, 1, 0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 0);
        conv("v42_nolz", 0, 8'd42, 0, 0, {7'h40, 7'h40, 7'h19, 7'h24}, 0);
        conv("b_v100", 1, 8'd100, 1, 0, {14'd0, 7'h3F, 7'h3F}, 1);
        conv("b_v99", 1, 8'd99, 1, 0, {14'd0, 7'h10, 7'h10}, 0);
        conv("b_v5_lz", 1, 8'd5, 1, 0, {14'd0, 7'h7F, 7'h12}, 0);
        conv("v42_drop", 0, 8'd42, 1, 1, {7'h7F, 7'h7F, 7'h19, 7'h24}, 0);

        // Reset five cycles into a conversion.
        @(negedge clk);
        set_load(0, 1'b1, 8'd200, 0);
        @(negedge clk);
        set_load(0, 1'b0, 8'd200, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", bus_a.seg_o, 28'hFFFFFFF);
        chk("midrst_busy", bus_a.busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_a.done_o) seen++;
        end
        chk("midrst_no_done", seen, 0);
        chk("midrst_seg_hold", bus_a.seg_o, 28'hFFFFFFF);
        prev_a = 28'hFFFFFFF;
        conv("after_rst", 0, 8'd123, 0, 0, {7'h40, 7'h79, 7'h24, 7'h30}, 0);

`ifdef SEG7_BLINK_EN
        begin
            int lit = 0;
            int dark = 0;
            int other_bad = 0;
            conv("blink_v7", 0, 8'd7, 1, 0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 0);
            bus_a.blink_mask_i = 4'b0001;
            repeat (64) begin
                @(negedge clk);
                if (bus_a.seg_o[6:0] == 7'h78) lit++;
                if (bus_a.seg_o[6:0] == 7'h7F) dark++;
                if (bus_a.seg_o[27:7] != {7'h7F, 7'h7F, 7'h7F}) other_bad++;
            end
            chk("blink_lit", lit, 32);
            chk("blink_dark", dark, 32);
            chk("blink_others", other_bad, 0);
            bus_a.blink_mask_i = 4'b0000;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
